// File: rtl/dmem_access_ctrl.sv
// Two-port data-memory sequencer: byte/half/word RMW on a word-wide memory; DMEM_MISALIGN_EN enables two-word split accesses.
// Latency grant->rsp: 2 cycles aligned, 3 split, 1 on error; one request in flight.
// Backpressure: reqN_ready pulses only in IDLE on grant; requesters hold their request until ready.
module dmem_access_ctrl #(
   parameter int DMEM_POWER = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_we,
   input  logic [2:0]  req0_size,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_we,
   input  logic [2:0]  req1_size,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic [2:0]  mem_memsize,
   input  logic [31:0] mem_rd
);
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   typedef struct packed {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   localparam logic [32:0] ADDR_LIMIT = 33'd1 << (DMEM_POWER + 2);
`ifdef DMEM_MISALIGN_EN
   localparam int RBW = 64;
`else
   localparam int RBW = 32;
`endif

   function automatic logic [2:0] nbytes(input logic [1:0] sz);
      case (sz)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] byte_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   byte_mask = 4'b0001;
         2'b01:   byte_mask = 4'b0011;
         default: byte_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] rd, input logic [31:0] dat,
                                         input logic [3:0] mask);
      for (int i = 0; i < 4; i++)
         merge[8*i +: 8] = mask[i] ? dat[8*i +: 8] : rd[8*i +: 8];
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] sz);
      case (sz)
         3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
         3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
         3'b100:  extend = {24'd0, raw[7:0]};
         3'b101:  extend = {16'd0, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   state_t         state_q, state_d;
   req_t           req_q, req_d, req_in;
   logic           port_q, port_d, prio_q, prio_d, err_q, err_d;
   logic [RBW-1:0] rbuf_q, rbuf_d;
   logic           gnt_vld, gnt_sel, in_err;
   logic [32:0]    last_byte;
   logic [31:0]    raw;

   // Both valid: the favoured port wins; otherwise whichever is valid.
   assign gnt_vld = req0_valid | req1_valid;
   assign gnt_sel = (req0_valid & req1_valid) ? prio_q : req1_valid;
   assign req_in  = gnt_sel ? {req1_we, req1_size, req1_addr, req1_wdata}
                            : {req0_we, req0_size, req0_addr, req0_wdata};
   assign last_byte = {1'b0, req_in.addr} + {30'd0, nbytes(req_in.size[1:0])} - 33'd1;

`ifdef DMEM_MISALIGN_EN
   logic [7:0]  lane_mask;
   logic [63:0] lane_data;
   logic        span;
   assign lane_mask = {4'b0000, byte_mask(req_q.size[1:0])} << req_q.addr[1:0];
   assign lane_data = {32'd0, req_q.wdata} << {req_q.addr[1:0], 3'b000};
   assign span      = ({1'b0, req_q.addr[1:0]} + nbytes(req_q.size[1:0])) > 3'd4;
   assign in_err    = (req_in.size == 3'b011) || (req_in.size[2] && req_in.size[1]) ||
                      (req_in.we && req_in.size[2]) || (last_byte >= ADDR_LIMIT);
`else
   logic [3:0]  lane_mask;
   logic [31:0] lane_data;
   assign lane_mask = byte_mask(req_q.size[1:0]) << req_q.addr[1:0];
   assign lane_data = req_q.wdata << {req_q.addr[1:0], 3'b000};
   assign in_err    = (req_in.size == 3'b011) || (req_in.size[2] && req_in.size[1]) ||
                      (req_in.we && req_in.size[2]) || (last_byte >= ADDR_LIMIT) ||
                      (({1'b0, req_in.addr[1:0]} + nbytes(req_in.size[1:0])) > 3'd4);
`endif

   assign raw         = 32'(rbuf_q >> {req_q.addr[1:0], 3'b000});
   assign mem_memsize = 3'b010;

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      port_d     = port_q;
      prio_d     = prio_q;
      err_d      = err_q;
      rbuf_d     = rbuf_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp_rdata  = 32'd0;
      rsp_err    = 1'b0;
      mem_we     = 1'b0;
      mem_a      = 32'd0;
      mem_wd     = 32'd0;
      if (!rst) begin
         case (state_q)
            IDLE: if (gnt_vld) begin
               req0_ready = ~gnt_sel;
               req1_ready = gnt_sel;
               req_d      = req_in;
               port_d     = gnt_sel;
               prio_d     = ~gnt_sel;
               err_d      = in_err;
               state_d    = in_err ? RESP : ACC0;
            end
            ACC0: begin
               mem_a = {req_q.addr[31:2], 2'b00};
               if (req_q.we) begin
                  mem_we = 1'b1;
                  mem_wd = merge(mem_rd, lane_data[31:0], lane_mask[3:0]);
               end else begin
                  rbuf_d[31:0] = mem_rd;
               end
`ifdef DMEM_MISALIGN_EN
               state_d = span ? ACC1 : RESP;
`else
               state_d = RESP;
`endif
            end
`ifdef DMEM_MISALIGN_EN
            ACC1: begin
               mem_a = {req_q.addr[31:2] + 30'd1, 2'b00};
               if (req_q.we) begin
                  mem_we = 1'b1;
                  mem_wd = merge(mem_rd, lane_data[63:32], lane_mask[7:4]);
               end else begin
                  rbuf_d[63:32] = mem_rd;
               end
               state_d = RESP;
            end
`endif
            RESP: begin
               rsp0_valid = ~port_q;
               rsp1_valid = port_q;
               rsp_err    = err_q;
               rsp_rdata  = (err_q || req_q.we) ? 32'd0 : extend(raw, req_q.size);
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         port_q  <= 1'b0;
         prio_q  <= 1'b0;
         err_q   <= 1'b0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         port_q  <= port_d;
         prio_q  <= prio_d;
         err_q   <= err_d;
         rbuf_q  <= rbuf_d;
      end
   end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: word memory model, response scoreboard, per-feature tasks.
module tb_dmem_access_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_we;
   logic [2:0]  req0_size;
   logic [31:0] req0_addr, req0_wdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [2:0]  req1_size;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp0_valid, rsp1_valid, rsp_err, mem_we;
   logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
   logic [2:0]  mem_memsize;

   logic [31:0] mem [0:(1<<18)-1];

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      bit          err;
      int          lat;
      int          gcyc;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_fail = 0;
   int n_we = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.DMEM_POWER(18)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_size(req0_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_size(req1_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_memsize(mem_memsize), .mem_rd(mem_rd)
   );

   assign mem_rd = mem[mem_a[19:2]];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_a[19:2]] <= mem_wd;
   end

   always @(negedge clk) begin
      #1;
      if (mem_we === 1'b1) n_we++;
   end

   // Response scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (rsp0_valid || rsp1_valid)) begin
         if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_unexpected: rsp0=%b rsp1=%b with no request outstanding", rsp0_valid, rsp1_valid);
         end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({rsp1_valid, rsp0_valid} !== (e.port ? 2'b10 : 2'b01)) begin
               n_fail++;
               $display("FAIL rsp_port: got rsp1/rsp0=%b%b want port %0d", rsp1_valid, rsp0_valid, e.port);
            end
            n_cmp++;
            if (rsp_rdata !== e.rdata) begin
               n_fail++;
               $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, e.rdata);
            end
            n_cmp++;
            if (rsp_err !== e.err) begin
               n_fail++;
               $display("FAIL rsp_err: got %b want %b", rsp_err, e.err);
            end
            n_cmp++;
            if (cyc - e.gcyc != e.lat) begin
               n_fail++;
               $display("FAIL rsp_latency: got %0d want %0d", cyc - e.gcyc, e.lat);
            end
         end
      end
   end

   task automatic wait_drain();
      int k = 0;
      while (sb.size() != 0 && k < 12) begin
         @(negedge clk); #2; k++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL rsp_timeout: %0d responses outstanding, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input bit port, input bit we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
      int k = 0;
      exp_t e;
      @(negedge clk);
      if (port) begin
         req1_we = we; req1_size = size; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
      end else begin
         req0_we = we; req0_size = size; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
      end
      #1;
      while (!(port ? req1_ready : req0_ready) && k < 20) begin
         @(negedge clk); #1; k++;
      end
      if (!(port ? req1_ready : req0_ready)) begin
         n_cmp++; n_fail++;
         $display("FAIL grant_timeout: port %0d ready=0 want 1", port);
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      e.port = port; e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.gcyc = cyc;
      sb.push_back(e);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #2;
      wait_drain();
   endtask

   // Holds both ports valid with loads and records the first ng_want grants.
   task automatic run_both(input int ng_want, output bit g[4], output int ng);
      int k = 0;
      exp_t e;
      ng = 0;
      @(negedge clk);
      req0_we = 1'b0; req0_size = 3'b010; req0_addr = 32'h10; req0_valid = 1'b1;
      req1_we = 1'b0; req1_size = 3'b010; req1_addr = 32'h20; req1_valid = 1'b1;
      while (ng < ng_want && k < 40) begin
         #1;
         if (req0_ready || req1_ready) begin
            g[ng] = req1_ready;
            e.port = req1_ready;
            e.rdata = req1_ready ? 32'h5A5A1234 : 32'h80013344;
            e.err = 1'b0; e.lat = 2; e.gcyc = cyc;
            sb.push_back(e);
            ng++;
         end
         @(negedge clk); k++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      #2;
      wait_drain();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b0; req0_size = 3'b010; req0_addr = 32'h0; req0_wdata = 32'h0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_size = 3'b010; req1_addr = 32'h0; req1_wdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         n_fail++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
      end
      n_cmp++;
      if ({rsp0_valid, rsp1_valid, rsp_err, rsp_rdata} !== 35'd0) begin
         n_fail++; $display("FAIL reset_rsp: got %b%b%b %h want all 0", rsp0_valid, rsp1_valid, rsp_err, rsp_rdata);
      end
      n_cmp++;
      if ({mem_we, mem_a, mem_wd} !== 65'd0) begin
         n_fail++; $display("FAIL reset_mem: got we=%b a=%h wd=%h want all 0", mem_we, mem_a, mem_wd);
      end
      n_cmp++;
      if (mem_memsize !== 3'b010) begin
         n_fail++; $display("FAIL reset_memsize: got %b want 010", mem_memsize);
      end
      req0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_word();
      issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
      n_cmp++;
      if (mem[4] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL sw_word4: got %h want deadbeef", mem[4]);
      end
      issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
   endtask

   task automatic test_subword();
      issue(1, 1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0, 2);
      issue(0, 1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 2);
      n_cmp++;
      if (mem[4] !== 32'hA5223344) begin
         n_fail++; $display("FAIL sb_word4: got %h want a5223344", mem[4]);
      end
      issue(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 2);
      issue(1, 0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 0, 2);
      issue(0, 0, 3'b000, 32'h10, 32'h0, 32'h00000044, 0, 2);
      issue(0, 1, 3'b001, 32'h12, 32'h00008001, 32'h0, 0, 2);
      n_cmp++;
      if (mem[4] !== 32'h80013344) begin
         n_fail++; $display("FAIL sh_word4: got %h want 80013344", mem[4]);
      end
      issue(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 0, 2);
      issue(1, 0, 3'b101, 32'h12, 32'h0, 32'h00008001, 0, 2);
   endtask

   task automatic test_arbitration();
      bit g[4];
      int ng;
      issue(1, 1, 3'b010, 32'h20, 32'h5A5A1234, 32'h0, 0, 2);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      run_both(4, g, ng);
      n_cmp++;
      if (ng != 4) begin
         n_fail++; $display("FAIL arb_grants: got %0d grants want 4", ng);
      end
      for (int i = 0; i < ng; i++) begin
         n_cmp++;
         if (g[i] != bit'(i % 2)) begin
            n_fail++; $display("FAIL arb_order[%0d]: got port %0d want %0d", i, g[i], i % 2);
         end
      end
   endtask

   task automatic test_misalign();
      int base;
      issue(0, 1, 3'b010, 32'h14, 32'h0, 32'h0, 0, 2);
      issue(0, 1, 3'b010, 32'h18, 32'h0, 32'h0, 0, 2);
      base = n_we;
`ifdef DMEM_MISALIGN_EN
      issue(0, 1, 3'b010, 32'h16, 32'hAABBCCDD, 32'h0, 0, 3);
      n_cmp++;
      if (mem[5] !== 32'hCCDD0000 || mem[6] !== 32'h0000AABB) begin
         n_fail++; $display("FAIL split_store: got %h %h want ccdd0000 0000aabb", mem[5], mem[6]);
      end
      n_cmp++;
      if (n_we - base != 2) begin
         n_fail++; $display("FAIL split_we_cycles: got %0d want 2", n_we - base);
      end
      issue(1, 0, 3'b010, 32'h16, 32'h0, 32'hAABBCCDD, 0, 3);
      issue(0, 0, 3'b101, 32'h17, 32'h0, 32'h0000BBCC, 0, 3);
      issue(0, 0, 3'b001, 32'h16, 32'h0, 32'hFFFFCCDD, 0, 2);
`else
      issue(0, 1, 3'b010, 32'h16, 32'hAABBCCDD, 32'h0, 1, 1);
      n_cmp++;
      if (mem[5] !== 32'h0 || mem[6] !== 32'h0) begin
         n_fail++; $display("FAIL split_store: got %h %h want 00000000 00000000", mem[5], mem[6]);
      end
      n_cmp++;
      if (n_we - base != 0) begin
         n_fail++; $display("FAIL split_we_cycles: got %0d want 0", n_we - base);
      end
      issue(1, 0, 3'b010, 32'h16, 32'h0, 32'h0, 1, 1);
      issue(0, 0, 3'b101, 32'h17, 32'h0, 32'h0, 1, 1);
      issue(0, 0, 3'b001, 32'h16, 32'h0, 32'h0, 0, 2);
`endif
   endtask

   task automatic test_errors();
      int base;
      issue(0, 1, 3'b010, 32'h000FFFFC, 32'h0BADF00D, 32'h0, 0, 2);
      issue(1, 0, 3'b010, 32'h000FFFFC, 32'h0, 32'h0BADF00D, 0, 2);
      base = n_we;
      issue(0, 0, 3'b001, 32'h000FFFFF, 32'h0, 32'h0, 1, 1);
      issue(0, 1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 1);
      issue(1, 1, 3'b101, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 1);
      issue(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
      issue(1, 0, 3'b111, 32'h10, 32'h0, 32'h0, 1, 1);
      issue(0, 1, 3'b010, 32'h00100000, 32'h12345678, 32'h0, 1, 1);
      n_cmp++;
      if (n_we != base) begin
         n_fail++; $display("FAIL err_no_we: got %0d write cycles want 0", n_we - base);
      end
      n_cmp++;
      if (mem[8] !== 32'h5A5A1234) begin
         n_fail++; $display("FAIL err_mem_intact: got %h want 5a5a1234", mem[8]);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      bit g[4];
      int ng;
      issue(1, 1, 3'b010, 32'h40, 32'h00000099, 32'h0, 0, 2);
      base = n_we;
      @(negedge clk);
      req0_we = 1'b1; req0_size = 3'b010; req0_addr = 32'h40; req0_wdata = 32'h12345678; req0_valid = 1'b1;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1) begin
         n_fail++; $display("FAIL midrst_grant: got ready=%b want 1", req0_ready);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (mem_we !== 1'b0) begin
         n_fail++; $display("FAIL midrst_we: got %b want 0", mem_we);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      n_cmp++;
      if (mem[16] !== 32'h00000099 || n_we != base) begin
         n_fail++; $display("FAIL midrst_mem: got %h (%0d writes) want 00000099 (0 writes)", mem[16], n_we - base);
      end
      run_both(1, g, ng);
      n_cmp++;
      if (ng != 1 || g[0] != 1'b0) begin
         n_fail++; $display("FAIL midrst_next_grant: got %0d grants port %0d want 1 grant port 0", ng, g[0]);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword();
      test_arbitration();
      test_misalign();
      test_errors();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
